// File: rtl/serial_subtractor_ctrl.sv
// Bit-serial subtractor (LSB first, WIDTH cycles per operation).
// Define SERIAL_SUB_SAT_EN to clamp diff to zero when a < b.
module serial_subtractor_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] diff,
  output logic             bor,
  output logic             busy,
  output logic             done
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] sh_q;
  logic [CW-1:0]    cnt_q;
  logic             br_q;
  logic [WIDTH-1:0] diff_q;
  logic             bor_q;
  logic             busy_q;
  logic             done_q;

  logic             d1;
  logic             b1;
  logic             di_d;
  logic             b2;
  logic             br_d;
  logic [WIDTH-1:0] sh_d;
  logic [WIDTH-1:0] diff_d;

  // Two cascaded half subtractors form the per-bit full subtract.
  always_comb begin
    d1   = a_q[0] ^ b_q[0];
    b1   = ~a_q[0] & b_q[0];
    di_d = d1 ^ br_q;
    b2   = ~d1 & br_q;
    br_d = b1 | b2;
    sh_d = {di_d, sh_q[WIDTH-1:1]};
`ifdef SERIAL_SUB_SAT_EN
    diff_d = br_d ? '0 : sh_d;
`else
    diff_d = sh_d;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sh_q    <= '0;
      cnt_q   <= '0;
      br_q    <= 1'b0;
      diff_q  <= '0;
      bor_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            a_q     <= a;
            b_q     <= b;
            cnt_q   <= '0;
            br_q    <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end
        end
        RUN: begin
          a_q   <= a_q >> 1;
          b_q   <= b_q >> 1;
          sh_q  <= sh_d;
          br_q  <= br_d;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == LAST) begin
            diff_q  <= diff_d;
            bor_q   <= br_d;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign diff = diff_q;
  assign bor  = bor_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule
